// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmitter arbiter and its round-robin picker.
// Pure declarations: no latency, no flow control.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    localparam int DEF_GAP_CYCLES     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 200000;

    // Index width for n requesters, never narrower than one bit.
    function automatic int REQ_IDX_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: first valid requester at or above rr_ptr, wrapping; purely combinational.
// Zero latency; no backpressure, win_vld low when nothing is requesting.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = REQ_IDX_W(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_vld
);

    int               pos;
    logic [IDX_W-1:0] idx;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_vld    = 1'b0;
        pos        = 0;
        idx        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = IDX_W'(pos);
            if (!win_vld && req_valid[idx]) begin
                win_vld         = 1'b1;
                win_onehot[idx] = 1'b1;
                win_idx         = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; optional watchdog under UART_ARB_TIMEOUT_EN.
// Accept in cycle N, tx_start in N+1 when the transmitter is idle; next accept GAP_CYCLES+1 after tx_done.
// Requesters are held off (req_ready low) until the frame and its gap complete.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [8*NUM_REQ-1:0]         req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_start,
    output logic [7:0]                   tx_data,
    output logic                         tx_en,
    input  logic                         tx_busy,
    input  logic                         tx_done,
    output logic [REQ_IDX_W(NUM_REQ)-1:0] grant_id,
    output logic                         active,
    input  logic                         err_clr,
    output logic                         timeout_err
);

    localparam int IDX_W = REQ_IDX_W(NUM_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_valid  (req_valid),
        .rr_ptr     (rr_ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_vld    (win_vld)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    data_d   = req_data[{win_idx, 3'b000} +: 8];
                    grant_d  = win_idx;
                    rr_ptr_d = (win_idx == PTR_LAST) ? '0 : win_idx + IDX_W'(1);
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (!tx_busy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx_done) begin
                    state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    gap_cnt_d = '0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef UART_ARB_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        err_d    = err_q & ~err_clr;
        if (state_q == ST_IDLE && win_vld) begin
            to_cnt_d = '0;
        end else if (state_q == ST_START || state_q == ST_WAIT) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            // Watchdog overrides a same-cycle tx_done and a same-cycle err_clr.
            if (to_cnt_q == TO_LAST) begin
                err_d     = 1'b1;
                state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                gap_cnt_d = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            gap_cnt_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            gap_cnt_q <= gap_cnt_d;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign req_ready = (state_q == ST_IDLE) ? win_onehot : '0;
    assign tx_start  = (state_q == ST_START) && !tx_busy;
    assign tx_en     = (state_q == ST_START) || (state_q == ST_WAIT);
    assign active    = (state_q != ST_IDLE);
    assign tx_data   = data_q;
    assign grant_id  = grant_q;

`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg  = err_clr ^ (TIMEOUT_CYCLES != 0);
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter: NUM_REQ=4, GAP=16, TIMEOUT=50.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        active;
    logic        err_clr;
    logic        timeout_err;

    typedef struct {
        logic [1:0] id;
        logic [7:0] dat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_wait;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .GAP_CYCLES     (16),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_en       (tx_en),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .active      (active),
        .err_clr     (err_clr),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [7:0] dat);
        exp_t e;
        e.id  = id;
        e.dat = dat;
        sb_q.push_back(e);
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        n_wait = 0;
        while (tx_start !== 1'b1 && n_wait < 100) begin
            tick();
            n_wait++;
        end
        chk(tag, int'(n_wait < 100), 1);
    endtask

    task automatic wait_idle(input string tag);
        n_wait = 0;
        while (active !== 1'b0 && n_wait < 100) begin
            tick();
            n_wait++;
        end
        chk(tag, int'(n_wait < 100), 1);
    endtask

    // Output side of the scoreboard: every start pulse must match the next expected grant.
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_grant", int'(grant_id), int'(mon_e.id));
                chk("sb_data", int'(tx_data), int'(mon_e.dat));
            end
        end
        if (req_ready !== 4'b0000) begin
            chk("rdy_onehot", int'($onehot(req_ready)), 1);
            chk("rdy_only_idle", int'(active), 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        err_clr   = 1'b0;
        repeat (3) tick();

        chk("rst_active", int'(active), 0);
        chk("rst_tx_en", int'(tx_en), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_grant", int'(grant_id), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        rst_n = 1'b0;
        tick();

        // Single request from requester 2.
        req_valid = 4'b0100;
        req_data  = 32'h00A5_0000;
        push_exp(2'd2, 8'hA5);
        #1;
        chk("single_ready", int'(req_ready), 4'b0100);
        tick();
        req_valid = '0;
        chk("single_start", int'(tx_start), 1);
        chk("single_tx_en", int'(tx_en), 1);
        chk("single_grant", int'(grant_id), 2);
        chk("single_data", int'(tx_data), 8'hA5);
        tick();
        chk("single_start_once", int'(tx_start), 0);
        chk("single_wait_en", int'(tx_en), 1);
        repeat (3) tick();
        chk("single_still_wait", int'(active), 1);
        pulse_done();
        chk("gap_tx_en", int'(tx_en), 0);
        chk("gap_active", int'(active), 1);
        n_wait = 0;
        while (active !== 1'b0 && n_wait < 40) begin
            tick();
            n_wait++;
        end
        chk("gap_len", n_wait, 16);

        // Stray done in IDLE.
        tx_done = 1'b1;
        #1;
        chk("stray_ready", int'(req_ready), 0);
        tick();
        tx_done = 1'b0;
        chk("stray_active", int'(active), 0);

        // Busy hold: rr_ptr is now 3, requester 1 wins.
        req_valid = 4'b0010;
        req_data  = 32'h0000_3C00;
        tx_busy   = 1'b1;
        push_exp(2'd1, 8'h3C);
        tick();
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < 5; i++) begin
            chk("busy_no_start", int'(tx_start), 0);
            chk("busy_data_held", int'(tx_data), 8'h3C);
            tick();
        end
        tx_busy = 1'b0;
        #1;
        chk("busy_release_start", int'(tx_start), 1);
        tick();
        chk("busy_start_once", int'(tx_start), 0);
        pulse_done();
        wait_idle("busy_idle");

        // Reset mid-frame: requester 0 is in WAIT when reset hits.
        req_valid = 4'b0001;
        req_data  = 32'h0000_0077;
        push_exp(2'd0, 8'h77);
        tick();
        req_valid = '0;
        tick();
        chk("mid_pre_active", int'(active), 1);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        chk("mid_active", int'(active), 0);
        chk("mid_tx_en", int'(tx_en), 0);
        chk("mid_tx_start", int'(tx_start), 0);
        chk("mid_tx_data", int'(tx_data), 0);
        chk("mid_grant", int'(grant_id), 0);
        chk("mid_ready", int'(req_ready), 0);

        // Fairness: rr_ptr back at 0, grant order 0,1,2,3,0.
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        push_exp(2'd0, 8'h10);
        push_exp(2'd1, 8'h11);
        push_exp(2'd2, 8'h12);
        push_exp(2'd3, 8'h13);
        push_exp(2'd0, 8'h10);
        for (int f = 0; f < 5; f++) begin
            wait_start("rr_start");
            if (f == 4) req_valid = '0;
            tick();
            tick();
            pulse_done();
        end
        wait_idle("rr_idle");
        chk("sb_drained", sb_q.size(), 0);

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: rr_ptr is 1, requester 2 wins; tx_done never arrives.
        req_valid = 4'b0100;
        req_data  = 32'h005A_0000;
        push_exp(2'd2, 8'h5A);
        tick();
        req_valid = '0;
        n_wait = 0;
        while (timeout_err !== 1'b1 && n_wait < 200) begin
            tick();
            n_wait++;
        end
        chk("wd_latency", n_wait, 50);
        chk("wd_gap_active", int'(active), 1);
        chk("wd_gap_tx_en", int'(tx_en), 0);
        wait_idle("wd_idle");
        chk("wd_sticky", int'(timeout_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("wd_cleared", int'(timeout_err), 0);
`else
        // No watchdog: the arbiter must sit in WAIT indefinitely.
        req_valid = 4'b0100;
        req_data  = 32'h005A_0000;
        push_exp(2'd2, 8'h5A);
        tick();
        req_valid = '0;
        repeat (300) tick();
        chk("nowd_active", int'(active), 1);
        chk("nowd_tx_en", int'(tx_en), 1);
        chk("nowd_err", int'(timeout_err), 0);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        chk("nowd_reset", int'(active), 0);
`endif
        chk("sb_final", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing the single UART transmitter among several on-chip byte sources, such as the APB bridge, a debug console and a DMA tap. It sits between the requesters and the transmitter's `tx_start` / `tx_data_in` / `tx_enable` / `done` / `busy` pins. It sequences one byte per grant and inserts a programmable inter-frame gap. No requester drives the transmitter directly.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `GAP_CYCLES`, default 16: idle clk cycles after each frame; 0 disables the gap.
- `TIMEOUT_CYCLES`, default 200000: watchdog limit in WAIT; used only with the macro.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: **synchronous, active-high reset**; high means reset, sampled on `clk` rising edge.
- `req_valid` in NUM_REQ: requester i has a byte pending.
- `req_data` in 8*NUM_REQ: byte of requester i in bits [8i+7:8i].
- `req_ready` out NUM_REQ: one-hot accept strobe.
- `tx_start` out 1: one-cycle start pulse to the transmitter.
- `tx_data` out 8: byte to the transmitter; registered.
- `tx_en` out 1: transmitter enable.
- `tx_busy` in 1: transmitter busy.
- `tx_done` in 1: one-cycle frame-complete pulse from the transmitter.
- `grant_id` out $clog2(NUM_REQ): index of the current or last owner.
- `active` out 1: high in every state except IDLE.
- `err_clr` in 1: clears `timeout_err`.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- States: IDLE, START, WAIT, GAP.
- **IDLE**
  - Winner is the first i with `req_valid[i]`=1, scanning from `rr_ptr` upward with wrap.
  - `req_ready[winner]`=1 combinationally in the same cycle; that cycle is the transfer.
  - On transfer: latch `req_data`, set `grant_id`=winner, set `rr_ptr`=(winner+1) mod NUM_REQ, go to START.
  - No valid request: stay in IDLE, `req_ready`=0.
- **START**
  - `tx_en`=1.
  - If `tx_busy`=0: `tx_start`=1 for exactly this cycle, then go to WAIT.
  - If `tx_busy`=1: hold in START with `tx_start`=0.
- **WAIT**
  - `tx_en`=1.
  - On `tx_done`=1: go to GAP, or to IDLE when GAP_CYCLES=0.
  - A `tx_done` seen in any other state is ignored.
- **GAP**
  - Counter counts 0..GAP_CYCLES-1, then go to IDLE.
  - `tx_en`=0.
- `req_ready` is 0 outside IDLE; at most one bit is high in any cycle.
- `tx_data` is stable from START entry until the next IDLE transfer.
- `rr_ptr` width is $clog2(NUM_REQ); wrap from NUM_REQ-1 to 0 is explicit, which also covers non-power-of-two NUM_REQ.
- A requester dropping `req_valid` before it is granted loses nothing; it is not selected.

## Timing
- Reset values:
  - State is IDLE.
  - `tx_start`, `tx_en`, `req_ready`, `active`, `timeout_err` = 0.
  - `tx_data`, `grant_id`, `rr_ptr`, gap counter, timeout counter = 0.
- Latency from accept in cycle N to `tx_start` in cycle N+1 when `tx_busy`=0.
- Back-to-back sends: the next accept comes GAP_CYCLES+1 cycles after `tx_done`.
- Reset asserted mid-frame: return to IDLE on the next edge and drop the in-flight byte. The transmitter shares `rst_n`.
- `err_clr` and a timeout in the same cycle: set wins.

## Configuration
- Macro `UART_ARB_TIMEOUT_EN`.
- Defined:
  - A counter runs in START and WAIT and is cleared on entry to START.
  - Reaching TIMEOUT_CYCLES sets `timeout_err`, sticky until `err_clr`, and forces GAP.
- Undefined:
  - No counter is built.
  - `timeout_err` is tied to 0 and `err_clr` is ignored.
  - START and WAIT may hold indefinitely.

## Structure
- Package `uart_arb_pkg` holds:
  - the state enum (IDLE/START/WAIT/GAP);
  - a `REQ_IDX_W` helper function;
  - the default GAP and TIMEOUT constants.
- Sub-module `rr_picker`: combinational. Takes `req_valid` and `rr_ptr`, returns the one-hot winner and its index. It is reusable by the APB arbiter.
- FSM, counters and data register live in `uart_tx_arbiter`.

## Test plan
- **Single request, basic send:** NUM_REQ=4, GAP=16. Requester 2 sends 0xA5 with `tx_busy`=0.
  - `req_ready[2]` is high for 1 cycle, `tx_start` fires the next cycle with `tx_data`=0xA5, `grant_id`=2.
  - After `tx_done`, IDLE is reached 16 cycles later.
- **Round-robin fairness:** all four `req_valid` held high with bytes 0x10..0x13.
  - Grant order is 0,1,2,3,0; each is granted exactly once per round.
- **Busy hold:** `tx_busy`=1 for 5 cycles after accept.
  - `tx_start` stays 0 for those 5 cycles, then pulses once.
  - `tx_data` is unchanged throughout.
- **Reset mid-frame:** `rst_n` pulsed high during WAIT.
  - Next cycle: state IDLE, all outputs at reset values, `rr_ptr`=0.
- **Watchdog:** with `UART_ARB_TIMEOUT_EN`, TIMEOUT=50, and `tx_done` never asserted.
  - `timeout_err` rises 50 cycles after START entry, then GAP, then IDLE.
  - `err_clr` drops the flag.
  - Without the macro the arbiter stays in WAIT.
- **Stray done:** `tx_done` pulsed in IDLE.
  - No state change and no `req_ready`.
